hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the five-stage pipelined core. It consumes the execute-stage destination and control outputs of the decode/execute pipeline register and tracks them through internal memory and writeback shadow registers. From that state it drives:
- stall and flush controls back into the fetch, decode/execute and later pipeline registers;
- operand-forwarding selects for the execute stage;
- saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline: load-use stalls,
// branch flushes, memory-busy freezes, operand forwarding and saturating event counters.
module hazard_ctrl #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    rs1D,
    input  logic [4:0]    rs2D,
    input  logic [4:0]    rs1E,
    input  logic [4:0]    rs2E,
    input  logic [5:0]    rdE,
    input  logic          reg_writeE,
    input  logic [1:0]    result_srcE,
    input  logic          pc_srcE,
    input  logic          mem_stall,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          stallM,
    output logic          flushD,
    output logic          flushE,
    output logic [1:0]    fwdAE,
    output logic [1:0]    fwdBE,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);

    logic [4:0] rdM;
    logic [4:0] rdW;
    logic       reg_writeM;
    logic       reg_writeW;
    logic       lwstall;
    logic [4:0] rd_e;
    logic       unused_rdE;

    // Bit 5 of the execute destination carries no register index.
    assign rd_e       = rdE[4:0];
    assign unused_rdE = rdE[5];

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wr_m, input logic [4:0] rd_w,
                                           input logic wr_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && wr_m && rd_m == rs) begin
            sel = 2'b10;
        end else if (rs != 5'd0 && wr_w && rd_w == rs) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        lwstall = (result_srcE == 2'b01) && reg_writeE && (rd_e != 5'd0) &&
                  ((rd_e == rs1D) || (rd_e == rs2D));
        stallF  = lwstall | mem_stall;
        stallD  = lwstall | mem_stall;
        stallE  = mem_stall;
        stallM  = mem_stall;
        // A frozen pipeline defers the flush; pc_srcE remains held until it can act.
        flushD  = pc_srcE & ~mem_stall;
        flushE  = (lwstall | pc_srcE) & ~mem_stall;
        fwdAE   = fwd_sel(rs1E, rdM, reg_writeM, rdW, reg_writeW);
        fwdBE   = fwd_sel(rs2E, rdM, reg_writeM, rdW, reg_writeW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdM        <= 5'd0;
            rdW        <= 5'd0;
            reg_writeM <= 1'b0;
            reg_writeW <= 1'b0;
        end else if (!mem_stall) begin
            rdM        <= rd_e;
            reg_writeM <= reg_writeE;
            rdW        <= rdM;
            reg_writeW <= reg_writeM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallF && stall_cnt != CntMax) begin
                stall_cnt <= stall_cnt + CntOne;
            end
            if (flushD && flush_cnt != CntMax) begin
                flush_cnt <= flush_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam int CW = 4;

    // {stallF, stallD, stallE, stallM, flushD, flushE}
    localparam logic [5:0] CtlNone = 6'b000000;
    localparam logic [5:0] CtlLw   = 6'b110001;
    localparam logic [5:0] CtlBr   = 6'b000011;
    localparam logic [5:0] CtlMs   = 6'b111100;
    localparam logic [5:0] CtlLwBr = 6'b110011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0;
    logic [5:0]    rdE = '0;
    logic          reg_writeE = 1'b0;
    logic [1:0]    result_srcE = '0;
    logic          pc_srcE = 1'b0;
    logic          mem_stall = 1'b0;
    logic          stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0]    fwdAE, fwdBE;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [5:0]    ctl;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        string         name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_ctrl #(.CW(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .reg_writeE(reg_writeE), .result_srcE(result_srcE),
        .pc_srcE(pc_srcE), .mem_stall(mem_stall),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .fwdAE(fwdAE), .fwdBE(fwdBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks += 5;
            if ({stallF, stallD, stallE, stallM, flushD, flushE} !== e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl: got %b expected %b", e.name,
                         {stallF, stallD, stallE, stallM, flushD, flushE}, e.ctl);
            end
            if (fwdAE !== e.fa) begin
                n_fail++;
                $display("FAIL %s fwdAE: got %b expected %b", e.name, fwdAE, e.fa);
            end
            if (fwdBE !== e.fb) begin
                n_fail++;
                $display("FAIL %s fwdBE: got %b expected %b", e.name, fwdBE, e.fb);
            end
            if (stall_cnt !== e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.sc);
            end
            if (flush_cnt !== e.fc) begin
                n_fail++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fc);
            end
        end
    end

    task automatic drive(input logic [4:0] r1d, input logic [4:0] r2d, input logic [4:0] r1e,
                         input logic [4:0] r2e, input logic [5:0] rde, input logic rwe,
                         input logic [1:0] rsrc, input logic pcs, input logic ms);
        @(posedge clk);
        #1;
        rs1D = r1d; rs2D = r2d; rs1E = r1e; rs2E = r2e;
        rdE = rde; reg_writeE = rwe; result_srcE = rsrc; pc_srcE = pcs; mem_stall = ms;
    endtask

    task automatic expect_out(input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc, input string name);
        exp_t x;
        x.ctl = ctl; x.fa = fa; x.fb = fb;
        x.sc = CW'(sc); x.fc = CW'(fc); x.name = name;
        q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Outputs stay combinational while held in reset
        drive(5, 0, 0, 0, 6'd5, 1, 2'b01, 0, 0); expect_out(CtlLw, 2'b00, 2'b00, 0, 0, "rst_lw");
        @(posedge clk); #1; rst = 1'b0;
        rs1D = 0; rdE = 0; reg_writeE = 0; result_srcE = 0;
        expect_out(CtlNone, 2'b00, 2'b00, 0, 0, "rst_state");
        // Load-use
        drive(5, 0, 0, 0, 6'd5, 1, 2'b01, 0, 0); expect_out(CtlLw, 2'b00, 2'b00, 0, 0, "lw_stall");
        drive(0, 0, 5, 0, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b10, 2'b00, 1, 0, "lw_fwdM");
        drive(0, 0, 5, 0, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b01, 2'b00, 1, 0, "lw_fwdW");
        // Forwarding priority on x7
        drive(0, 0, 0, 0, 6'd7, 1, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b00, 1, 0, "x7_wr1");
        drive(0, 0, 0, 0, 6'd7, 1, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b00, 1, 0, "x7_wr2");
        drive(0, 0, 0, 7, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b10, 1, 0, "prio_M");
        drive(0, 0, 0, 7, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b01, 1, 0, "prio_W");
        // x0 never forwarded
        drive(0, 0, 0, 0, 6'd0, 1, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b00, 1, 0, "x0_a");
        drive(0, 0, 0, 0, 6'd0, 1, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b00, 1, 0, "x0_b");
        drive(0, 0, 0, 0, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b00, 1, 0, "x0_c");
        // rdE bit 5 ignored
        drive(0, 3, 0, 0, 6'h23, 1, 2'b01, 0, 0); expect_out(CtlLw, 2'b00, 2'b00, 1, 0, "rd_bit5");
        drive(0, 0, 3, 3, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b10, 2'b10, 2, 0, "rd_bit5_fwd");
        // Branch flush
        drive(0, 0, 0, 0, 6'd0, 0, 2'b00, 1, 0); expect_out(CtlBr, 2'b00, 2'b00, 2, 0, "branch");
        drive(0, 0, 0, 0, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b00, 2'b00, 2, 1, "branch_cnt");
        // Load-use and branch together
        drive(4, 0, 0, 0, 6'd4, 1, 2'b01, 1, 0); expect_out(CtlLwBr, 2'b00, 2'b00, 2, 1, "lw_br");
        // Memory stall defers flush and freezes shadow state
        drive(0, 0, 4, 0, 6'd9, 1, 2'b00, 1, 1); expect_out(CtlMs, 2'b10, 2'b00, 3, 2, "ms1");
        drive(9, 0, 4, 0, 6'd9, 1, 2'b01, 1, 1); expect_out(CtlMs, 2'b10, 2'b00, 4, 2, "ms2_lw");
        drive(0, 0, 4, 0, 6'd9, 1, 2'b00, 1, 1); expect_out(CtlMs, 2'b10, 2'b00, 5, 2, "ms3");
        drive(0, 0, 4, 0, 6'd9, 1, 2'b00, 1, 0); expect_out(CtlBr, 2'b10, 2'b00, 6, 2, "ms_release");
        drive(0, 0, 4, 9, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b01, 2'b10, 6, 3, "ms_after");
        // Saturation of stall_cnt
        for (int k = 0; k <= 20; k++) begin
            drive(5, 0, 0, 0, 6'd5, 1, 2'b01, 0, 0);
            expect_out(CtlLw, 2'b00, 2'b00, (6 + k > 15) ? 15 : 6 + k, 3, "sat");
        end
        drive(0, 0, 5, 5, 6'd0, 0, 2'b00, 0, 0); expect_out(CtlNone, 2'b10, 2'b10, 15, 3, "pre_rst");
        // Asynchronous reset between edges
        drive(0, 0, 5, 5, 6'd0, 0, 2'b00, 0, 0);
        #2 rst = 1'b1;
        expect_out(CtlNone, 2'b00, 2'b00, 0, 0, "async_rst");
        @(posedge clk); #1; rst = 1'b0;
        expect_out(CtlNone, 2'b00, 2'b00, 0, 0, "post_rst");
        @(negedge clk); #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
